// File: rtl/rv_pkg.sv
// Shared pipeline types for the EX stage and its multiply/divide unit.
package rv_pkg;

   localparam int MDU_ITERS_DEF = 32;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_BUSY,
      MDU_DONE
   } mdu_state_e;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] wb_sel;
   } wb_ctrl_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] mem_size;
   } mem_ctrl_reg_t;

   typedef struct packed {
      wb_ctrl_t      wb_ctrl;
      mem_ctrl_reg_t mem_ctrl;
      logic [31:0]   alu_out;
      logic [31:0]   read_data2;
      logic [4:0]    inst_rd;
   } ex_mem_regs_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply
// and restoring divide on magnitudes, sharing one 64-bit shift register and one adder.
//
// state     | meaning
// MDU_IDLE  | waiting for an M op; accepts and latches operands
// MDU_BUSY  | one radix-2 step per cycle, MDU_ITERS steps
// MDU_DONE  | sign fix-up applied, result presented for one cycle
module ex_muldiv
   import rv_pkg::*;
#(
   parameter int MDU_ITERS = MDU_ITERS_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  mdu_op_e      i_op,
   input  logic [31:0]  i_rs1,
   input  logic [31:0]  i_rs2,
   input  logic [4:0]   i_rd,
   input  wb_ctrl_t     i_wb_ctrl,
   input  logic         i_flush,
   output logic         o_stall,
   output logic         o_valid,
   output ex_mem_regs_t o_ex_mem_regs
);

   localparam int CNT_W = $clog2(MDU_ITERS + 1);

   mdu_state_e       state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      acc;
   logic [31:0]      opnd;
   mdu_op_e          op_q;
   logic [4:0]       rd_q;
   wb_ctrl_t         wb_q;
   logic             neg_q, neg_r;

   logic        s1, s2, a_neg, b_neg, is_div_in, div_zero, div_ovf, special, accept;
   logic [31:0] a_mag, b_mag;
   logic        is_div_q, ge;
   logic [32:0] add_a, add_b, sum;
   logic [63:0] acc_step, prod;
   logic [31:0] quo, rem, result;

   assign is_div_in = i_op[2];
   assign s1        = (i_op != MDU_MULHU) && (i_op != MDU_DIVU) && (i_op != MDU_REMU);
   assign s2        = s1 && (i_op != MDU_MULHSU);
   assign a_neg     = s1 & i_rs1[31];
   assign b_neg     = s2 & i_rs2[31];
   assign a_mag     = a_neg ? (32'd0 - i_rs1) : i_rs1;
   assign b_mag     = b_neg ? (32'd0 - i_rs2) : i_rs2;
   assign div_zero  = is_div_in && (i_rs2 == 32'd0);
   assign div_ovf   = is_div_in && s1 && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
   assign special   = div_zero | div_ovf;
   assign accept    = (state == MDU_IDLE) && i_valid && !i_flush;

   // Divide uses the 33-bit window acc[63:31] so the bit shifted out of the
   // partial remainder still takes part in the compare.
   assign is_div_q = op_q[2];
   assign add_a    = is_div_q ? acc[63:31] : {1'b0, acc[63:32]};
   assign add_b    = is_div_q ? ~{1'b0, opnd} : (acc[0] ? {1'b0, opnd} : 33'd0);
   assign sum      = add_a + add_b + {32'd0, is_div_q};
   assign ge       = acc[63] | ~sum[32];
   assign acc_step = is_div_q ? {(ge ? sum[31:0] : acc[62:31]), acc[30:0], ge}
                              : {sum, acc[31:1]};

   assign prod = neg_q ? (64'd0 - acc) : acc;
   assign quo  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
   assign rem  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

   always_comb begin
      result = prod[63:32];
      case (op_q)
         MDU_MUL:                 result = prod[31:0];
         MDU_DIV, MDU_DIVU:       result = quo;
         MDU_REM, MDU_REMU:       result = rem;
         default:                 result = prod[63:32];
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         MDU_IDLE: if (i_valid) state_n = special ? MDU_DONE : MDU_BUSY;
         MDU_BUSY: if (cnt == CNT_W'(MDU_ITERS - 1)) state_n = MDU_DONE;
         MDU_DONE: state_n = MDU_IDLE;
         default:  state_n = MDU_IDLE;
      endcase
      if (i_flush) state_n = MDU_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= MDU_IDLE;
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         op_q  <= MDU_MUL;
         rd_q  <= '0;
         wb_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_q <= i_op;
            rd_q <= i_rd;
            wb_q <= i_wb_ctrl;
            cnt  <= '0;
            // Special cases preload acc so the normal DONE read-out yields the answer.
            if (div_zero) begin
               acc   <= {i_rs1, 32'hFFFF_FFFF};
               opnd  <= '0;
               neg_q <= 1'b0;
               neg_r <= 1'b0;
            end else if (div_ovf) begin
               acc   <= {32'd0, 32'h8000_0000};
               opnd  <= '0;
               neg_q <= 1'b0;
               neg_r <= 1'b0;
            end else if (is_div_in) begin
               acc   <= {32'd0, a_mag};
               opnd  <= b_mag;
               neg_q <= a_neg ^ b_neg;
               neg_r <= a_neg;
            end else begin
               acc   <= {32'd0, b_mag};
               opnd  <= a_mag;
               neg_q <= a_neg ^ b_neg;
               neg_r <= 1'b0;
            end
         end else if ((state == MDU_BUSY) && !i_flush) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign o_stall = i_rst && (((state == MDU_IDLE) && i_valid && !i_flush) || (state == MDU_BUSY));
   assign o_valid = i_rst && (state == MDU_DONE) && !i_flush;

   always_comb begin
      o_ex_mem_regs = '0;
      if (o_valid) begin
         o_ex_mem_regs.alu_out = result;
         o_ex_mem_regs.inst_rd = rd_q;
         o_ex_mem_regs.wb_ctrl = wb_q;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: results, latency, stall, flush and reset.
module tb_ex_muldiv;
   import rv_pkg::*;

   logic         i_clk = 1'b0;
   logic         i_rst, i_valid, i_flush;
   mdu_op_e      i_op;
   logic [31:0]  i_rs1, i_rs2;
   logic [4:0]   i_rd;
   wb_ctrl_t     i_wb_ctrl;
   logic         o_stall, o_valid;
   ex_mem_regs_t o_ex_mem_regs;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   ex_muldiv dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_op         (i_op),
      .i_rs1        (i_rs1),
      .i_rs2        (i_rs2),
      .i_rd         (i_rd),
      .i_wb_ctrl    (i_wb_ctrl),
      .i_flush      (i_flush),
      .o_stall      (o_stall),
      .o_valid      (o_valid),
      .o_ex_mem_regs(o_ex_mem_regs)
   );

   // Drives one op starting at posedge+1 and returns what the DUT produced;
   // returns at posedge+1 of the cycle after DONE with i_valid low.
   task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output ex_mem_regs_t res, output int lat,
                         output int stalls, output logic done_stall, output logic valid_after);
      i_op      = op;
      i_rs1     = a;
      i_rs2     = b;
      i_rd      = rd;
      i_wb_ctrl = '{reg_write: 1'b1, wb_sel: 2'b01};
      i_valid   = 1'b1;
      #1;
      stalls = o_stall ? 1 : 0;
      lat    = 0;
      while (lat < 40) begin
         @(posedge i_clk); #1;
         lat++;
         if (o_valid) break;
         if (o_stall) stalls++;
      end
      res        = o_ex_mem_regs;
      done_stall = o_stall;
      i_valid    = 1'b0;
      @(posedge i_clk); #1;
      valid_after = o_valid;
   endtask

   task automatic test_reset;
      i_rst = 1'b0; i_valid = 1'b1; i_op = MDU_DIVU; i_rs1 = 32'd9; i_rs2 = 32'd0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_stall); end
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
      checks++;
      if (o_ex_mem_regs !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", o_ex_mem_regs); end
      i_rst = 1'b1; i_valid = 1'b0;
      @(posedge i_clk); #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got stall %b valid %b exp 0 0", o_stall, o_valid);
      end
   endtask

   task automatic test_mul;
      mdu_op_e     ops [6] = '{MDU_MUL, MDU_MULHU, MDU_MULH, MDU_MULHSU, MDU_MULH, MDU_MULH};
      logic [31:0] av  [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bv  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'd1};
      logic [31:0] ev  [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF};
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], av[i], bv[i], 5'(i + 1), r, lat, st, ds, va);
         checks++;
         if (r.alu_out !== ev[i]) begin errors++; $display("FAIL mul_result[%0d] got %h exp %h", i, r.alu_out, ev[i]); end
         checks++;
         if (lat !== 33) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp 33", i, lat); end
         checks++;
         if (st !== 33) begin errors++; $display("FAIL mul_stall_cycles[%0d] got %0d exp 33", i, st); end
         checks++;
         if (r.inst_rd !== 5'(i + 1) || r.wb_ctrl !== 3'b101 || r.mem_ctrl !== '0 || r.read_data2 !== '0) begin
            errors++; $display("FAIL mul_fields[%0d] got rd %0d wb %b mem %b rd2 %h exp rd %0d wb 101 mem 0 rd2 0",
                               i, r.inst_rd, r.wb_ctrl, r.mem_ctrl, r.read_data2, i + 1);
         end
         checks++;
         if (ds !== 1'b0 || va !== 1'b0) begin
            errors++; $display("FAIL mul_done_shape[%0d] got done_stall %b next_valid %b exp 0 0", i, ds, va);
         end
      end
   endtask

   task automatic test_div;
      mdu_op_e     ops [8] = '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU};
      logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] ev  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'd1, 32'h7FFF_FFFF};
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], av[i], bv[i], 5'(i + 8), r, lat, st, ds, va);
         checks++;
         if (r.alu_out !== ev[i]) begin errors++; $display("FAIL div_result[%0d] got %h exp %h", i, r.alu_out, ev[i]); end
         checks++;
         if (lat !== 33 || st !== 33) begin
            errors++; $display("FAIL div_timing[%0d] got lat %0d stalls %0d exp 33 33", i, lat, st);
         end
      end
   endtask

   task automatic test_special;
      mdu_op_e     ops [6] = '{MDU_DIVU, MDU_REM, MDU_DIV, MDU_REM, MDU_DIV, MDU_REMU};
      logic [31:0] av  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
      logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], av[i], bv[i], 5'd0, r, lat, st, ds, va);
         checks++;
         if (r.alu_out !== ev[i]) begin errors++; $display("FAIL special_result[%0d] got %h exp %h", i, r.alu_out, ev[i]); end
         checks++;
         if (lat !== 1 || st !== 1 || va !== 1'b0) begin
            errors++; $display("FAIL special_timing[%0d] got lat %0d stalls %0d next_valid %b exp 1 1 0", i, lat, st, va);
         end
      end
   endtask

   task automatic test_flush;
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      i_op = MDU_MUL; i_rs1 = 32'd3; i_rs2 = 32'd4; i_valid = 1'b1; i_flush = 1'b1;
      #1;
      checks++;
      if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b exp 0", o_stall); end
      @(posedge i_clk); #1;
      i_flush = 1'b0; i_valid = 1'b0;
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_idle_no_accept got stall %b valid %b exp 0 0", o_stall, o_valid);
      end
      i_op = MDU_MUL; i_rs1 = 32'd7; i_rs2 = 32'hFFFF_FFFD; i_valid = 1'b1;
      repeat (10) @(posedge i_clk);
      #1;
      i_flush = 1'b1; i_valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_valid got %b exp 0", o_valid); end
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_busy_idle got stall %b valid %b exp 0 0", o_stall, o_valid);
      end
      run_op(MDU_DIVU, 32'd100, 32'd7, 5'd3, r, lat, st, ds, va);
      checks++;
      if (r.alu_out !== 32'd14 || lat !== 33) begin
         errors++; $display("FAIL flush_next_op got %h lat %0d exp 0000000e lat 33", r.alu_out, lat);
      end
   endtask

   task automatic test_rst_mid;
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      longint t0, t1;
      i_op = MDU_DIVU; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd = 5'd9; i_valid = 1'b1;
      repeat (20) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL rst_during got stall %b valid %b exp 0 0", o_stall, o_valid);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b1; i_valid = 1'b0;
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0 || o_ex_mem_regs !== '0) begin
         errors++; $display("FAIL rst_after got stall %b valid %b regs %h exp all 0", o_stall, o_valid, o_ex_mem_regs);
      end
      @(posedge i_clk); #1;
      t0 = longint'($time);
      run_op(MDU_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, r, lat, st, ds, va);
      checks++;
      if (r.alu_out !== 32'hFFFF_FFFF || lat !== 33) begin
         errors++; $display("FAIL rst_b2b_first got %h lat %0d exp ffffffff lat 33", r.alu_out, lat);
      end
      t1 = longint'($time);
      run_op(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, r, lat, st, ds, va);
      checks++;
      if (r.alu_out !== 32'hFFFF_FFEB || lat !== 33 || r.inst_rd !== 5'd5) begin
         errors++; $display("FAIL rst_b2b_second got %h lat %0d rd %0d exp ffffffeb lat 33 rd 5", r.alu_out, lat, r.inst_rd);
      end
      checks++;
      if (t1 - t0 !== 64'd340) begin errors++; $display("FAIL rst_b2b_period got %0d exp 340", t1 - t0); end
   endtask

   task automatic test_back_to_back;
      ex_mem_regs_t r;
      int lat, st;
      logic ds, va;
      logic [31:0] got;
      i_op = MDU_DIVU; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd = 5'd6; i_valid = 1'b1;
      lat = 0;
      got = '0;
      while (lat < 40) begin
         @(posedge i_clk); #1;
         lat++;
         if (o_valid) begin got = o_ex_mem_regs.alu_out; break; end
      end
      checks++;
      if (got !== 32'd14 || lat !== 33) begin
         errors++; $display("FAIL held_valid_result got %h lat %0d exp 0000000e lat 33", got, lat);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_valid !== 1'b0) begin
         errors++; $display("FAIL done_ignores_valid got stall %b valid %b exp 0 0", o_stall, o_valid);
      end
      @(posedge i_clk); #1;
      run_op(MDU_DIVU, 32'd5, 32'd0, 5'd7, r, lat, st, ds, va);
      checks++;
      if (r.alu_out !== 32'hFFFF_FFFF || lat !== 1) begin
         errors++; $display("FAIL b2b_special got %h lat %0d exp ffffffff lat 1", r.alu_out, lat);
      end
      run_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, r, lat, st, ds, va);
      checks++;
      if (r.alu_out !== 32'hFFFF_FFFE || lat !== 33) begin
         errors++; $display("FAIL b2b_after_special got %h lat %0d exp fffffffe lat 33", r.alu_out, lat);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_op = MDU_MUL;
      i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_wb_ctrl = '0;
      test_reset;
      test_mul;
      test_div;
      test_special;
      test_flush;
      test_rst_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
